// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester arbiter feeding one registered output slot
// Tie policy: fixed priority to Input1; define ROUND_ROBIN_EN for round-robin on ties.
module mux_arbiter #(
    parameter int WIDTH     = 17,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Req1,
    input  logic [WIDTH-1:0]     Input1,
    input  logic                 Req2,
    input  logic [WIDTH-1:0]     Input2,
    output logic                 Ack1,
    output logic                 Ack2,
    output logic                 Selection,
    output logic [WIDTH-1:0]     Output,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [CNT_WIDTH-1:0] GrantCount1,
    output logic [CNT_WIDTH-1:0] GrantCount2
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   elig1;
    logic   elig2;
    logic   capture;
    logic   winner;
    logic   tie_winner;

    // A requester whose Ack is high is still showing the item just taken.
    assign elig1 = Req1 & ~Ack1;
    assign elig2 = Req2 & ~Ack2;

`ifdef ROUND_ROBIN_EN
    logic last_grant;

    assign tie_winner = ~last_grant;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_grant <= 1'b1;
        end else if (capture) begin
            last_grant <= winner;
        end
    end
`else
    assign tie_winner = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        winner    = 1'b0;
        if (elig1 && elig2) begin
            winner = tie_winner;
        end else begin
            winner = elig2;
        end
        if (state == EMPTY) begin
            if (elig1 || elig2) begin
                capture   = 1'b1;
                state_nxt = FULL;
            end
        end else if (OutReady) begin
            if (elig1 || elig2) begin
                capture = 1'b1;
            end else begin
                state_nxt = EMPTY;
            end
        end
    end

    assign OutValid = (state == FULL);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Output      <= '0;
            Selection   <= 1'b0;
            Ack1        <= 1'b0;
            Ack2        <= 1'b0;
            GrantCount1 <= '0;
            GrantCount2 <= '0;
        end else begin
            Ack1 <= capture & ~winner;
            Ack2 <= capture & winner;
            if (capture) begin
                Output    <= winner ? Input2 : Input1;
                Selection <= winner;
                if (!winner && GrantCount1 != CNT_MAX) begin
                    GrantCount1 <= GrantCount1 + CNT_WIDTH'(1);
                end
                if (winner && GrantCount2 != CNT_MAX) begin
                    GrantCount2 <= GrantCount2 + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
